// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing, per-pixel layer requests, priority compositor and crash detect.
// Latency: counters -> req_*_o 1 cycle; counters -> VGA pins and crash flags LAYER_LAT+2 cycles.
// Backpressure: none; free-running pixel pipeline, layers must answer exactly LAYER_LAT cycles after a request.
//
// Optional build macro VGA_BORDER_EN: when defined, the outermost ring of active pixels is forced
// to all-ones colour, overriding every layer (crash flags unaffected).
//
// Ports:
//   clk_vga, rst           pixel clock; asynchronous active-low reset
//   en_i                   game running; low shows background only and masks crash flags
//   bg/enemy/me/bullet     layer colour and alpha returned LAYER_LAT cycles after each request
//   req_x/y_addr_o         requested pixel, held at the last active value during blanking
//   req_valid_o            request lies in the active area
//   v_sync_o               one-cycle frame tick at start of vertical blank
//   vga_hs_o/vs_o/rgb_o    VGA pins (syncs active low, rgb 0 in blanking)
//   crash_*_o              per-pixel opaque overlap flags, aligned with rgb

`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif
`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 9
`endif

module vga_scan_ctrl #(
   parameter int H_DISP    = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISP    = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int LAYER_LAT = 1
) (
   input  logic                        clk_vga,
   input  logic                        rst,
   input  logic                        en_i,
   input  logic [`COLOR_RGB_DEPTH-1:0] bg_rgb_i,
   input  logic                        enemy_alpha_i,
   input  logic [`COLOR_RGB_DEPTH-1:0] enemy_rgb_i,
   input  logic                        me_alpha_i,
   input  logic [`COLOR_RGB_DEPTH-1:0] me_rgb_i,
   input  logic                        bullet_alpha_i,
   input  logic [`COLOR_RGB_DEPTH-1:0] bullet_rgb_i,
   output logic [`H_DISP_LEN-1:0]      req_x_addr_o,
   output logic [`V_DISP_LEN-1:0]      req_y_addr_o,
   output logic                        req_valid_o,
   output logic                        v_sync_o,
   output logic                        vga_hs_o,
   output logic                        vga_vs_o,
   output logic [`COLOR_RGB_DEPTH-1:0] vga_rgb_o,
   output logic                        crash_enemy_bullet_o,
   output logic                        crash_me_enemy_o
);

   localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XW      = `H_DISP_LEN;
   localparam int YW      = `V_DISP_LEN;
   localparam int CW      = `COLOR_RGB_DEPTH;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_DISP);
   localparam logic [HW-1:0] HS_BEG = HW'(H_DISP + H_FRONT);
   localparam logic [HW-1:0] HS_END = HW'(H_DISP + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_DISP);
   localparam logic [VW-1:0] VS_BEG = VW'(V_DISP + V_FRONT);
   localparam logic [VW-1:0] VS_END = VW'(V_DISP + V_FRONT + V_SYNC);
`ifdef VGA_BORDER_EN
   localparam logic [HW-1:0] H_EDGE = HW'(H_DISP - 1);
   localparam logic [VW-1:0] V_EDGE = VW'(V_DISP - 1);
`endif

   // Per-pixel control that travels alongside the layer round trip.
   typedef struct packed {
      logic vld;
      logic hs;
      logic vs;
`ifdef VGA_BORDER_EN
      logic edge_px;
`endif
   } align_t;

   // Idle value: syncs inactive (high), nothing valid.
   function automatic align_t idle_align();
      align_t a;
      a    = '0;
      a.hs = 1'b1;
      a.vs = 1'b1;
      return a;
   endfunction

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          act_c;
   align_t        s0_nxt;
   align_t        s0;
   align_t        pipe [LAYER_LAT];
   align_t        al;

   logic [CW-1:0] rgb_nxt;
   logic          ceb_nxt;
   logic          cme_nxt;

   // Raster counters.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign act_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);

   always_comb begin
      s0_nxt     = idle_align();
      s0_nxt.vld = act_c;
      s0_nxt.hs  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      s0_nxt.vs  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
`ifdef VGA_BORDER_EN
      s0_nxt.edge_px = (h_cnt == '0) || (h_cnt == H_EDGE) || (v_cnt == '0) || (v_cnt == V_EDGE);
`endif
   end

   // Stage 0: request to the layers plus the frame tick.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         s0           <= idle_align();
         req_x_addr_o <= '0;
         req_y_addr_o <= '0;
         v_sync_o     <= 1'b0;
      end else begin
         s0       <= s0_nxt;
         v_sync_o <= (h_cnt == '0) && (v_cnt == V_ACT);
         // Address holds through blanking so layers see a stable last pixel.
         if (act_c) begin
            req_x_addr_o <= XW'(h_cnt);
            req_y_addr_o <= YW'(v_cnt);
         end
      end
   end

   assign req_valid_o = s0.vld;

   // Delay line matching the layer round trip; pipe[LAYER_LAT-1] lines up with layer data.
   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAYER_LAT; i++) pipe[i] <= idle_align();
      end else begin
         pipe[0] <= s0;
         for (int i = 1; i < LAYER_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign al = pipe[LAYER_LAT-1];

   // Compositor: me > bullet > enemy > background; blanking forces black and no crashes.
   always_comb begin
      rgb_nxt = '0;
      ceb_nxt = 1'b0;
      cme_nxt = 1'b0;
      if (al.vld) begin
         if (!en_i)               rgb_nxt = bg_rgb_i;
         else if (me_alpha_i)     rgb_nxt = me_rgb_i;
         else if (bullet_alpha_i) rgb_nxt = bullet_rgb_i;
         else if (enemy_alpha_i)  rgb_nxt = enemy_rgb_i;
         else                     rgb_nxt = bg_rgb_i;
         ceb_nxt = en_i & enemy_alpha_i & bullet_alpha_i;
         cme_nxt = en_i & me_alpha_i & enemy_alpha_i;
`ifdef VGA_BORDER_EN
         if (al.edge_px) rgb_nxt = '1;
`endif
      end
   end

   always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
         vga_hs_o             <= 1'b1;
         vga_vs_o             <= 1'b1;
         vga_rgb_o            <= '0;
         crash_enemy_bullet_o <= 1'b0;
         crash_me_enemy_o     <= 1'b0;
      end else begin
         vga_hs_o             <= al.hs;
         vga_vs_o             <= al.vs;
         vga_rgb_o            <= rgb_nxt;
         crash_enemy_bullet_o <= ceb_nxt;
         crash_me_enemy_o     <= cme_nxt;
      end
   end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: scoreboard bench for vga_scan_ctrl on a reduced raster plus one full-size instance.
// Latency: expectations queued per counter cycle, compared when the pins are due.
// Backpressure: none.

`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 12
`endif
`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 9
`endif

module tb_vga_scan_ctrl;

   localparam int HD = 16, HF = 2, HS = 3, HB = 3;
   localparam int VD = 8,  VF = 2, VS = 1, VB = 2;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int CW = `COLOR_RGB_DEPTH;
   localparam int XW = `H_DISP_LEN;
   localparam int YW = `V_DISP_LEN;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic [CW-1:0] rgb;
      logic          ceb;
      logic          cme;
   } pins_t;

   typedef struct packed {
      logic          vld;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          tick;
   } req_t;

   localparam pins_t PIN_IDLE = '{hs: 1'b1, vs: 1'b1, rgb: '0, ceb: 1'b0, cme: 1'b0};
   localparam logic [CW-1:0] BG_B = CW'(32'h5A5);

   logic clk_vga;
   logic rst;
   logic en_i;

   logic [CW-1:0] bg_a, enemy_rgb_a, me_rgb_a, bullet_rgb_a, rgb_a;
   logic          enemy_alpha_a, me_alpha_a, bullet_alpha_a;
   logic [XW-1:0] req_x_a;
   logic [YW-1:0] req_y_a;
   logic          req_vld_a, tick_a, hs_a, vs_a, ceb_a, cme_a;

   logic [CW-1:0] me_rgb_b, rgb_b;
   logic [XW-1:0] req_x_b;
   logic [YW-1:0] req_y_b;
   logic          req_vld_b, tick_b, hs_b, vs_b, ceb_b, cme_b;

   logic [CW-1:0] zero_rgb, rgb_f;
   logic          zero_bit, one_bit;
   logic [XW-1:0] req_x_f;
   logic [YW-1:0] req_y_f;
   logic          req_vld_f, tick_f, hs_f, vs_f, ceb_f, cme_f;

   vga_scan_ctrl #(.H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LAYER_LAT(LAT_A)) dut (
      .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .bg_rgb_i(bg_a),
      .enemy_alpha_i(enemy_alpha_a), .enemy_rgb_i(enemy_rgb_a),
      .me_alpha_i(me_alpha_a), .me_rgb_i(me_rgb_a),
      .bullet_alpha_i(bullet_alpha_a), .bullet_rgb_i(bullet_rgb_a),
      .req_x_addr_o(req_x_a), .req_y_addr_o(req_y_a), .req_valid_o(req_vld_a),
      .v_sync_o(tick_a), .vga_hs_o(hs_a), .vga_vs_o(vs_a), .vga_rgb_o(rgb_a),
      .crash_enemy_bullet_o(ceb_a), .crash_me_enemy_o(cme_a));

   vga_scan_ctrl #(.H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LAYER_LAT(LAT_B)) dut_lat3 (
      .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .bg_rgb_i(BG_B),
      .enemy_alpha_i(zero_bit), .enemy_rgb_i(zero_rgb),
      .me_alpha_i(one_bit), .me_rgb_i(me_rgb_b),
      .bullet_alpha_i(zero_bit), .bullet_rgb_i(zero_rgb),
      .req_x_addr_o(req_x_b), .req_y_addr_o(req_y_b), .req_valid_o(req_vld_b),
      .v_sync_o(tick_b), .vga_hs_o(hs_b), .vga_vs_o(vs_b), .vga_rgb_o(rgb_b),
      .crash_enemy_bullet_o(ceb_b), .crash_me_enemy_o(cme_b));

   vga_scan_ctrl dut_full (
      .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .bg_rgb_i(zero_rgb),
      .enemy_alpha_i(zero_bit), .enemy_rgb_i(zero_rgb),
      .me_alpha_i(zero_bit), .me_rgb_i(zero_rgb),
      .bullet_alpha_i(zero_bit), .bullet_rgb_i(zero_rgb),
      .req_x_addr_o(req_x_f), .req_y_addr_o(req_y_f), .req_valid_o(req_vld_f),
      .v_sync_o(tick_f), .vga_hs_o(hs_f), .vga_vs_o(vs_f), .vga_rgb_o(rgb_f),
      .crash_enemy_bullet_o(ceb_f), .crash_me_enemy_o(cme_f));

   initial clk_vga = 1'b0;
   always #5 clk_vga = ~clk_vga;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Layer stimulus: frame 0 is sparse (priority pixels only), later frames a dense mix.
   // Blanking always carries opaque layers, which must never reach the pins.
   function automatic logic [2:0] alpha_pat(input int x, input int y, input int f); // {me,bullet,enemy}
      if (x >= HD || y >= VD) return 3'b111;
      if (f == 0) begin
         if (x == 10 && y == 5) return 3'b011;
         if (x == 11 && y == 5) return 3'b111;
         return 3'b000;
      end
      return 3'((x + 3 * y + f) % 8);
   endfunction

   function automatic logic [CW-1:0] enemy_col(input int x);  return CW'(32'h100 + x); endfunction
   function automatic logic [CW-1:0] bullet_col(input int y); return CW'(32'h200 + y); endfunction
   function automatic logic [CW-1:0] me_col(input int x, input int y); return CW'(32'h300 + x + y); endfunction
   function automatic logic [CW-1:0] bg_col(input int x, input int y); return CW'(32'h0F0 ^ (x + 16 * y)); endfunction
   function automatic logic en_of(input int f); return (f != 2); endfunction

   function automatic logic is_edge(input int x, input int y);
      return (x == 0) || (x == HD - 1) || (y == 0) || (y == VD - 1);
   endfunction

   function automatic pins_t sync_of(input int h, input int v);
      pins_t p;
      p    = '0;
      p.hs = !(h >= HD + HF && h < HD + HF + HS);
      p.vs = !(v >= VD + VF && v < VD + VF + VS);
      return p;
   endfunction

   function automatic pins_t exp_a(input int h, input int v, input int f);
      pins_t p;
      logic [2:0] a;
      p = sync_of(h, v);
      if (h < HD && v < VD) begin
         a = alpha_pat(h, v, f);
         if (!en_of(f)) p.rgb = bg_col(h, v);
         else if (a[2]) p.rgb = me_col(h, v);
         else if (a[1]) p.rgb = bullet_col(v);
         else if (a[0]) p.rgb = enemy_col(h);
         else           p.rgb = bg_col(h, v);
         p.ceb = en_of(f) & a[0] & a[1];
         p.cme = en_of(f) & a[2] & a[0];
`ifdef VGA_BORDER_EN
         if (is_edge(h, v)) p.rgb = '1;
`endif
      end
      return p;
   endfunction

   // Latency-3 instance: its layer echoes req_x, so active pixels show their own x.
   function automatic pins_t exp_b(input int h, input int v, input int f);
      pins_t p;
      p = sync_of(h, v);
      if (h < HD && v < VD) begin
         p.rgb = en_of(f) ? CW'(h) : BG_B;
`ifdef VGA_BORDER_EN
         if (is_edge(h, v)) p.rgb = '1;
`endif
      end
      return p;
   endfunction

   pins_t q_a[$];
   pins_t q_b[$];
   req_t  q_r[$];
   int    q_pa[$];
   int    q_pb[$];

   int f_fall1, f_rise1, f_fall2;
   int ticks_a, ticks_b, ticks_en_low;

   // Runs ncyc cycles from a reset release made at a negedge.
   task automatic run_scan(input int ncyc, input bit watch_full);
      int h, v, f, p, ph, pv, pf, lx, ly, pix;
      logic [2:0] al;
      logic [XW-1:0] echo [3];
      logic hs_f_prev;
      pins_t ea, eb;
      req_t  er;
      lx = 0; ly = 0; hs_f_prev = 1'b1;
      for (int i = 0; i < 3; i++) echo[i] = '0;
      q_a.delete(); q_b.delete(); q_r.delete(); q_pa.delete(); q_pb.delete();
      repeat (LAT_A + 2) begin q_a.push_back(PIN_IDLE); q_pa.push_back(-1); end
      repeat (LAT_B + 2) begin q_b.push_back(PIN_IDLE); q_pb.push_back(-1); end
      q_r.push_back('0);
      f_fall1 = -1; f_rise1 = -1; f_fall2 = -1;
      ticks_a = 0; ticks_b = 0; ticks_en_low = 0;
      for (int k = 0; k < ncyc; k++) begin
         // Outputs visible in this cycle.
         ea = q_a.pop_front(); pix = q_pa.pop_front();
         check_eq($sformatf("pins_lat1 px%0d (%0d,%0d)", pix, pix % HT, (pix / HT) % VT),
                  64'({hs_a, vs_a, rgb_a, ceb_a, cme_a}), 64'(ea));
         eb = q_b.pop_front(); pix = q_pb.pop_front();
         check_eq($sformatf("pins_lat3 px%0d (%0d,%0d)", pix, pix % HT, (pix / HT) % VT),
                  64'({hs_b, vs_b, rgb_b, ceb_b, cme_b}), 64'(eb));
         er = q_r.pop_front();
         check_eq($sformatf("req cycle%0d", k), 64'({req_vld_a, req_x_a, req_y_a, tick_a}), 64'(er));
         if (tick_a) begin
            ticks_a++;
            if (k >= 1 && (k - 1) / FT == 2) ticks_en_low++;
         end
         if (tick_b) ticks_b++;
         if (watch_full) begin
            if (hs_f_prev && !hs_f) begin
               if (f_fall1 < 0) f_fall1 = k;
               else if (f_fall2 < 0) f_fall2 = k;
            end
            if (!hs_f_prev && hs_f && f_rise1 < 0) f_rise1 = k;
            hs_f_prev = hs_f;
         end
         // Expectations for the counter state of this cycle.
         h = k % HT; v = (k / HT) % VT; f = k / FT;
         q_a.push_back(exp_a(h, v, f)); q_pa.push_back(k);
         q_b.push_back(exp_b(h, v, f)); q_pb.push_back(k);
         if (h < HD && v < VD) begin lx = h; ly = v; end
         er.vld  = (h < HD && v < VD);
         er.x    = XW'(lx);
         er.y    = YW'(ly);
         er.tick = (h == 0 && v == VD);
         q_r.push_back(er);
         // Layer data sampled at the end of this cycle.
         p  = (k < LAT_A + 1) ? 0 : k - LAT_A - 1;
         ph = p % HT; pv = (p / HT) % VT; pf = p / FT;
         al = alpha_pat(ph, pv, pf);
         en_i           = en_of(pf);
         me_alpha_a     = al[2];
         bullet_alpha_a = al[1];
         enemy_alpha_a  = al[0];
         me_rgb_a       = me_col(ph, pv);
         bullet_rgb_a   = bullet_col(pv);
         enemy_rgb_a    = enemy_col(ph);
         bg_a           = bg_col(ph, pv);
         me_rgb_b       = CW'(echo[2]);
         echo[2] = echo[1]; echo[1] = echo[0]; echo[0] = req_x_b;
         @(negedge clk_vga);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en_i = 1'b1;
      zero_rgb = '0; zero_bit = 1'b0; one_bit = 1'b1;
      bg_a = '0; enemy_rgb_a = '0; me_rgb_a = '0; bullet_rgb_a = '0; me_rgb_b = '0;
      enemy_alpha_a = 1'b0; me_alpha_a = 1'b0; bullet_alpha_a = 1'b0;
      repeat (3) @(negedge clk_vga);
      check_eq("reset_pins", 64'({hs_a, vs_a, rgb_a, ceb_a, cme_a}), 64'(PIN_IDLE));
      check_eq("reset_req", 64'({req_vld_a, req_x_a, req_y_a, tick_a}), 64'(0));
      check_eq("reset_full_sync", 64'({hs_f, vs_f}), 64'(2'b11));

      rst = 1'b1;
      run_scan(5 * FT + 4 * HT + 7, 1'b1);
      check_eq("full_hs_first_fall", 64'(f_fall1), 64'(656 + 1 + 2));
      check_eq("full_hs_low_width", 64'(f_rise1 - f_fall1), 64'(96));
      check_eq("full_hs_period", 64'(f_fall2 - f_fall1), 64'(800));
      check_eq("full_vs_idle", 64'(vs_f), 64'(1));
      check_eq("tick_count_lat1", 64'(ticks_a), 64'(5));
      check_eq("tick_count_lat3", 64'(ticks_b), 64'(5));
      check_eq("tick_with_en_low", 64'(ticks_en_low), 64'(1));

      // Asynchronous reset in the middle of an active line, away from any clock edge.
      #2 rst = 1'b0;
      #1;
      check_eq("async_rst_pins_lat1", 64'({hs_a, vs_a, rgb_a, ceb_a, cme_a}), 64'(PIN_IDLE));
      check_eq("async_rst_req", 64'({req_vld_a, req_x_a, req_y_a, tick_a}), 64'(0));
      check_eq("async_rst_pins_lat3", 64'({hs_b, vs_b, rgb_b, ceb_b, cme_b}), 64'(PIN_IDLE));
      repeat (3) @(negedge clk_vga);
      rst = 1'b1;
      run_scan(2 * FT + 10, 1'b0);
      check_eq("tick_count_after_rst", 64'(ticks_a), 64'(2));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
